chaos_xor_cipher: RTL and testbench

CHAOS_XOR_CIPHER -- requirements
Module: chaos_xor_cipher

---
 rtl/chaos_xor_cipher_pkg.sv | 33 +++
 rtl/chaos_key_buffer.sv | 54 +++++
 rtl/chaos_xor_cipher.sv | 146 ++++++++++++++
 tb/tb_chaos_xor_cipher.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_xor_cipher_pkg.sv
// Shared types and constants for the chaos keystream XOR cipher.
// Keystream words pack the generator outputs as {X, Y, Z, W}, X in the top byte.
package chaos_xor_cipher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REINIT,
        ST_FETCH,
        ST_GAP,
        ST_HOLD
    } fetch_state_t;

    typedef logic [31:0] ks_word_t;

    localparam logic [1:0] BYTE_X = 2'd0;
    localparam logic [1:0] BYTE_Y = 2'd1;
    localparam logic [1:0] BYTE_Z = 2'd2;
    localparam logic [1:0] BYTE_W = 2'd3;

    localparam logic [31:0] DEFAULT_SEED = 32'h447a0000;

    function automatic logic [7:0] ks_byte(input ks_word_t w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            BYTE_X:  b = w[31:24];
            BYTE_Y:  b = w[23:16];
            BYTE_Z:  b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/chaos_key_buffer.sv
// Double-buffered keystream: a pending word filled by the fetcher and an active word
// consumed one byte at a time; pending moves to active whenever active is (or becomes) empty.
module chaos_key_buffer
    import chaos_xor_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       load,
    input  ks_word_t   load_word,
    input  logic       consume,
    output logic [7:0] key_byte,
    output logic       act_valid,
    output logic       pend_valid,
    output logic       move
);

    ks_word_t   act_word;
    ks_word_t   pend_word;
    logic [1:0] idx;
    logic       last_byte;

    assign last_byte = consume && (idx == BYTE_W);
    // Moving on the same cycle as the last byte is taken avoids a bubble between words.
    assign move      = !flush && pend_valid && (!act_valid || last_byte);
    assign key_byte  = ks_byte(act_word, idx);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            act_word   <= '0;
            pend_word  <= '0;
            idx        <= BYTE_X;
            act_valid  <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (move) begin
                act_word   <= pend_word;
                act_valid  <= 1'b1;
                idx        <= BYTE_X;
                pend_valid <= 1'b0;
            end else if (consume) begin
                idx <= idx + 2'd1;
                if (idx == BYTE_W) begin
                    act_valid <= 1'b0;
                end
            end
            if (load) begin
                pend_word  <= load_word;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/chaos_xor_cipher.sv
// XORs a byte stream with keystream words fetched from an external chaos generator.
// One-cycle accept-to-output latency; input stalls while the output is held or no keystream is ready.
module chaos_xor_cipher
    import chaos_xor_cipher_pkg::*;
#(
    parameter int GAP_CYCLES   = 1,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] KEY,
    output logic        CH_STEP,
    output logic        CH_RESET,
    output logic [31:0] CH_SHIFT,
    input  logic        CH_DONE,
    input  logic [7:0]  CH_X,
    input  logic [7:0]  CH_Y,
    input  logic [7:0]  CH_Z,
    input  logic [7:0]  CH_W,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [7:0]  IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  OUT_DATA,
    output logic        ERR
);

    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

    fetch_state_t state;
    logic [15:0]  gap_cnt;
    logic [15:0]  step_cnt;

    logic         load;
    logic         accept;
    logic         act_valid;
    logic         pend_valid;
    logic         move;
    logic [7:0]   key_byte;

    assign load     = (state == ST_FETCH) && CH_DONE && !START;
    assign IN_READY = act_valid && (!OUT_VALID || OUT_READY)
                      && (state != ST_IDLE) && (state != ST_REINIT);
    assign accept   = IN_VALID && IN_READY;

    chaos_key_buffer u_buf (
        .clk        (CLK),
        .reset      (RESET),
        .flush      (START),
        .load       (load),
        .load_word  ({CH_X, CH_Y, CH_Z, CH_W}),
        .consume    (accept),
        .key_byte   (key_byte),
        .act_valid  (act_valid),
        .pend_valid (pend_valid),
        .move       (move)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            CH_STEP  <= 1'b0;
            CH_RESET <= 1'b0;
            CH_SHIFT <= '0;
            ERR      <= 1'b0;
            gap_cnt  <= '0;
            step_cnt <= '0;
        end else if (START) begin
            state    <= ST_REINIT;
            CH_STEP  <= 1'b0;
            CH_RESET <= 1'b1;
            CH_SHIFT <= KEY;
            ERR      <= 1'b0;
            gap_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    CH_STEP  <= 1'b0;
                    CH_RESET <= 1'b0;
                end
                ST_REINIT: begin
                    state    <= ST_FETCH;
                    CH_RESET <= 1'b0;
                    CH_STEP  <= 1'b1;
                    step_cnt <= '0;
                end
                ST_FETCH: begin
                    if (CH_DONE) begin
                        state   <= ST_GAP;
                        CH_STEP <= 1'b0;
                        gap_cnt <= '0;
                    end else if (step_cnt == TIMEOUT_LAST) begin
                        state   <= ST_IDLE;
                        CH_STEP <= 1'b0;
                        ERR     <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        // A pending word leaving this very cycle frees the slot for the next fetch.
                        if (pend_valid && !move) begin
                            state <= ST_HOLD;
                        end else begin
                            state    <= ST_FETCH;
                            CH_STEP  <= 1'b1;
                            step_cnt <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (!pend_valid || move) begin
                        state    <= ST_FETCH;
                        CH_STEP  <= 1'b1;
                        step_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    CH_STEP  <= 1'b0;
                    CH_RESET <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= IN_DATA ^ key_byte;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chaos_xor_cipher.sv
// Bench for chaos_xor_cipher with a behavioural generator stub (done after 52 step cycles,
// words 11223344 then +01010101) and a scoreboard of expected output bytes.
module tb_chaos_xor_cipher;
    import chaos_xor_cipher_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] key;
    logic        ch_step;
    logic        ch_reset;
    logic [31:0] ch_shift;
    logic        ch_done;
    logic [7:0]  ch_x, ch_y, ch_z, ch_w;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        err;

    chaos_xor_cipher #(.GAP_CYCLES(1), .DONE_TIMEOUT(255)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .KEY       (key),
        .CH_STEP   (ch_step),
        .CH_RESET  (ch_reset),
        .CH_SHIFT  (ch_shift),
        .CH_DONE   (ch_done),
        .CH_X      (ch_x),
        .CH_Y      (ch_y),
        .CH_Z      (ch_z),
        .CH_W      (ch_w),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DATA   (in_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stub
    logic [31:0] stub_word;
    logic [7:0]  stub_cnt;
    logic        stub_en;

    assign ch_done = stub_en && ch_step && (stub_cnt == 8'd51);
    assign {ch_x, ch_y, ch_z, ch_w} = stub_word;

    always @(posedge clk) begin
        if (rst || ch_reset) begin
            stub_word <= 32'h11223344;
            stub_cnt  <= 8'd0;
        end else if (ch_step) begin
            if (ch_done) begin
                stub_cnt  <= 8'd0;
                stub_word <= stub_word + 32'h01010101;
            end else begin
                stub_cnt <= stub_cnt + 8'd1;
            end
        end
    end

    int   done_cnt = 0;
    logic step_pend_seen = 1'b0;

    always @(negedge clk) begin
        if (ch_done) done_cnt <= done_cnt + 1;
        if (ch_step && dut.u_buf.pend_valid) step_pend_seen <= 1'b1;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] k);
        key   = k;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_wait: IN_READY stayed 0 for byte %h, expected 1", d);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #2;
            in_valid = 1'b0;
            chk("latency_valid", 32'(out_valid), 32'd1);
            chk("latency_data", 32'(out_data), 32'(e));
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[5];
        logic [7:0] ks12[12];
        int         n, m, ok, base;

        tbl[0] = '{8'h00, 8'h11};
        tbl[1] = '{8'h00, 8'h22};
        tbl[2] = '{8'h00, 8'h33};
        tbl[3] = '{8'h00, 8'h44};
        tbl[4] = '{8'hFF, 8'hED};
        ks12 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12, 8'h23, 8'h34, 8'h45,
                 8'h13, 8'h24, 8'h35, 8'h46};

        rst = 1'b1; start = 1'b0; key = 32'h0; in_valid = 1'b0; in_data = 8'h0;
        out_ready = 1'b1; stub_en = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got %h with no byte expected", out_data);
                    end else begin
                        chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        chk("rst_step", 32'(ch_step), 32'd0);
        chk("rst_chreset", 32'(ch_reset), 32'd0);
        chk("rst_shift", ch_shift, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Start-up fetch timing
        pulse_start(DEFAULT_SEED);
        chk("reinit_chreset", 32'(ch_reset), 32'd1);
        chk("reinit_step", 32'(ch_step), 32'd0);
        chk("shift_key", ch_shift, DEFAULT_SEED);
        @(posedge clk); #2;
        chk("reinit_one_cycle", 32'(ch_reset), 32'd0);
        n = 0;
        while (ch_step && n < 500) begin n++; @(posedge clk); #2; end
        chk("step_run", 32'(n), 32'd52);
        m = 0;
        while (!ch_step && m < 500) begin m++; @(posedge clk); #2; end
        chk("gap_run", 32'(m), 32'd1);

        // Basic XOR table, crossing into the second word
        for (int i = 0; i < 5; i++) send(tbl[i].din, tbl[i].dout);

        // Output backpressure
        @(posedge clk); #2;
        out_ready = 1'b0;
        send(8'h00, 8'h23);
        in_valid = 1'b1;
        in_data  = 8'h77;
        ok = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data === 8'h23 && in_ready === 1'b0) ok++;
        end
        chk("stall_hold", 32'(ok), 32'd10);
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        send(8'h00, 8'h34);
        send(8'h00, 8'h45);

        // START after two bytes of a word discards the rest
        send(8'h00, 8'h13);
        send(8'h00, 8'h24);
        pulse_start(32'hdeadbeef);
        chk("shift_new_key", ch_shift, 32'hdeadbeef);
        key = 32'h0;
        @(posedge clk); #2;
        chk("shift_stable", ch_shift, 32'hdeadbeef);
        send(8'h00, 8'h11);

        // START held two cycles restarts REINIT, then a 12-byte stream
        key   = DEFAULT_SEED;
        start = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b0;
        base  = done_cnt;
        chk("reinit_restart", 32'(ch_reset), 32'd1);
        @(posedge clk); #2;
        chk("reinit_done", 32'(ch_reset), 32'd0);
        for (int i = 0; i < 12; i++) begin
            send(8'(i * 19 + 5), 8'(i * 19 + 5) ^ ks12[i]);
        end
        chk("three_fetches", 32'(done_cnt - base), 32'd3);
        chk("no_step_while_pending", 32'(step_pend_seen), 32'd0);
        chk("stream_err", 32'(err), 32'd0);

        // Generator never completes
        stub_en = 1'b0;
        pulse_start(DEFAULT_SEED);
        @(posedge clk); #2;
        n = 0;
        while (ch_step && n < 1000) begin n++; @(posedge clk); #2; end
        chk("timeout_steps", 32'(n), 32'd255);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_in_ready", 32'(in_ready), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        chk("idle_no_step", 32'(ch_step), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);
        stub_en = 1'b1;
        pulse_start(DEFAULT_SEED);
        chk("start_clears_err", 32'(err), 32'd0);
        send(8'h5A, 8'h4B);

        // RESET wins over START and handshakes in the same cycle
        @(posedge clk); #2;
        rst      = 1'b1;
        start    = 1'b1;
        key      = 32'h12345678;
        in_valid = 1'b1;
        @(posedge clk); #2;
        chk("rst_prio_chreset", 32'(ch_reset), 32'd0);
        chk("rst_prio_shift", ch_shift, 32'd0);
        chk("rst_prio_out_valid", 32'(out_valid), 32'd0);
        chk("rst_prio_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #2;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
